// File: rtl/instr_fetch_if.sv
// Fetch/decoder bus for the 12-bit baseline core: program-memory port,
// executing-instruction bus, decoder flow-control strobes and status flags.
interface instr_fetch_if #(
    parameter int PC_W = 11
);
    localparam int PA_W = (PC_W > 9) ? PC_W - 9 : 1;

    logic [PC_W-1:0] pm_addr;
    logic [11:0]     pm_data;
    logic [11:0]     instr;
    logic            goto;
    logic            call;
    logic            retlw;
    logic            pcl_wr;
    logic [7:0]      pcl_data;
    logic            skip;
    logic            sleep;
    logic            wake;
    logic [PA_W-1:0] pa;
    logic            sleeping;
    logic            stk_ovf;
    logic            stk_unf;

    modport master (
        output pm_addr, instr, sleeping, stk_ovf, stk_unf,
        input  pm_data, goto, call, retlw, pcl_wr, pcl_data, skip, sleep, wake, pa
    );

    modport slave (
        input  pm_addr, instr, sleeping, stk_ovf, stk_unf,
        output pm_data, goto, call, retlw, pcl_wr, pcl_data, skip, sleep, wake, pa
    );
endinterface

// File: rtl/instr_fetch.sv
// Instruction fetch/sequencer: PC, 2-level return stack and IR for the 12-bit core.
// Optional stack depth checking is enabled by defining INSTR_FETCH_STK_CHK_EN.
module instr_fetch #(
    parameter int              PC_W      = 11,
    parameter logic [PC_W-1:0] RESET_VEC = {PC_W{1'b1}},
    parameter logic [11:0]     NOP_WORD  = 12'h000
) (
    input  logic           clk,
    input  logic           rst_n,
    instr_fetch_if.master  bus
);

    logic [PC_W-1:0] pc_q, pc_d;
    logic [PC_W-1:0] stk1_q, stk1_d;
    logic [PC_W-1:0] stk2_q, stk2_d;
    logic [11:0]     ir_q, ir_d;
    logic            sleeping_q, sleeping_d;

    logic [PC_W-1:0] pc_inc_s;
    logic [PC_W-1:0] goto_tgt_s;
    logic [PC_W-1:0] call_tgt_s;
    logic [PC_W-1:0] pcl_tgt_s;

    assign pc_inc_s = pc_q + {{(PC_W-1){1'b0}}, 1'b1};

    // Page bits only exist above 512 words; CALL and PCL writes can only reach the lower half-page.
    generate
        if (PC_W > 9) begin : g_paged
            assign goto_tgt_s = {bus.pa, ir_q[8:0]};
            assign call_tgt_s = {bus.pa, 1'b0, ir_q[7:0]};
            assign pcl_tgt_s  = {bus.pa, 1'b0, bus.pcl_data};
        end else begin : g_flat
            assign goto_tgt_s = ir_q[8:0];
            assign call_tgt_s = {1'b0, ir_q[7:0]};
            assign pcl_tgt_s  = {1'b0, bus.pcl_data};
        end
    endgenerate

    // Next-state sequencing; the if-chain order is the strobe priority.
    always_comb begin
        pc_d       = pc_q;
        ir_d       = ir_q;
        stk1_d     = stk1_q;
        stk2_d     = stk2_q;
        sleeping_d = sleeping_q;
        if (sleeping_q) begin
            if (bus.wake) begin
                sleeping_d = 1'b0;
            end else begin
                sleeping_d = 1'b1;
            end
        end else if (bus.sleep) begin
            sleeping_d = 1'b1;
            ir_d       = NOP_WORD;
        end else if (bus.retlw) begin
            pc_d   = stk1_q;
            stk1_d = stk2_q;
            ir_d   = NOP_WORD;
        end else if (bus.call) begin
            pc_d   = call_tgt_s;
            stk1_d = pc_q;
            stk2_d = stk1_q;
            ir_d   = NOP_WORD;
        end else if (bus.goto) begin
            pc_d = goto_tgt_s;
            ir_d = NOP_WORD;
        end else if (bus.pcl_wr) begin
            pc_d = pcl_tgt_s;
            ir_d = NOP_WORD;
        end else if (bus.skip) begin
            pc_d = pc_inc_s;
            ir_d = NOP_WORD;
        end else begin
            pc_d = pc_inc_s;
            ir_d = bus.pm_data;
        end
    end

    // Core fetch state registers.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            pc_q       <= RESET_VEC;
            ir_q       <= NOP_WORD;
            stk1_q     <= {PC_W{1'b0}};
            stk2_q     <= {PC_W{1'b0}};
            sleeping_q <= 1'b0;
        end else begin
            pc_q       <= pc_d;
            ir_q       <= ir_d;
            stk1_q     <= stk1_d;
            stk2_q     <= stk2_d;
            sleeping_q <= sleeping_d;
        end
    end

`ifdef INSTR_FETCH_STK_CHK_EN
    logic [1:0] depth_q, depth_d;
    logic       ovf_q, ovf_d;
    logic       unf_q, unf_d;
    logic       push_s;
    logic       pop_s;

    // A push/pop only happens when call/retlw actually wins arbitration.
    assign pop_s  = !sleeping_q && !bus.sleep && bus.retlw;
    assign push_s = !sleeping_q && !bus.sleep && !bus.retlw && bus.call;

    // Saturating depth tracking with sticky error flags.
    always_comb begin
        depth_d = depth_q;
        ovf_d   = ovf_q;
        unf_d   = unf_q;
        if (push_s) begin
            if (depth_q == 2'd2) begin
                ovf_d = 1'b1;
            end else begin
                depth_d = depth_q + 2'd1;
            end
        end else if (pop_s) begin
            if (depth_q == 2'd0) begin
                unf_d = 1'b1;
            end else begin
                depth_d = depth_q - 2'd1;
            end
        end else begin
            depth_d = depth_q;
        end
    end

    // Stack-check registers.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            depth_q <= 2'd0;
            ovf_q   <= 1'b0;
            unf_q   <= 1'b0;
        end else begin
            depth_q <= depth_d;
            ovf_q   <= ovf_d;
            unf_q   <= unf_d;
        end
    end

    assign bus.stk_ovf = ovf_q;
    assign bus.stk_unf = unf_q;
`else
    assign bus.stk_ovf = 1'b0;
    assign bus.stk_unf = 1'b0;
`endif

    assign bus.pm_addr  = pc_q;
    assign bus.instr    = ir_q;
    assign bus.sleeping = sleeping_q;

endmodule

// File: tb/tb_instr_fetch.sv
// Directed-vector bench for instr_fetch: ROM[i]=i with a few patched words,
// hand-computed pm_addr/instr/flag expectations after each clock.
module tb_instr_fetch;

`ifdef INSTR_FETCH_STK_CHK_EN
    localparam logic STK_CHK = 1'b1;
`else
    localparam logic STK_CHK = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst_n;
    int   vectors = 0;
    int   miscompares = 0;
    logic [11:0] rom [2048];

    instr_fetch_if #(.PC_W(11)) bus ();

    instr_fetch #(.PC_W(11)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus.master)
    );

    always #5 clk = ~clk;

    assign bus.pm_data = rom[bus.pm_addr];

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic chk_fetch(input string tag, input logic [10:0] exp_addr, input logic [11:0] exp_instr);
        chk({tag, ".pm_addr"}, {21'd0, bus.pm_addr}, {21'd0, exp_addr});
        chk({tag, ".instr"}, {20'd0, bus.instr}, {20'd0, exp_instr});
    endtask

    task automatic pcl_jump(input logic [7:0] target);
        bus.pa       = 2'b00;
        bus.pcl_data = target;
        bus.pcl_wr   = 1'b1;
        step();
        bus.pcl_wr   = 1'b0;
        chk_fetch("pcl", {3'b000, target}, 12'h000);
    endtask

    initial begin
        for (int i = 0; i < 2048; i++) rom[i] = i[11:0];
        rom[11'h010] = 12'h155;
        rom[11'h020] = 12'h940;
        rom[11'h060] = 12'h970;
        rom[11'h070] = 12'h980;
        rom[11'h080] = 12'h990;

        rst_n = 1'b0;
        bus.goto = 1'b0; bus.call = 1'b0; bus.retlw = 1'b0; bus.pcl_wr = 1'b0;
        bus.pcl_data = 8'h00; bus.skip = 1'b0; bus.sleep = 1'b0; bus.wake = 1'b0;
        bus.pa = 2'b00;

        // Reset state
        step();
        chk_fetch("reset", 11'h7FF, 12'h000);
        chk("reset.sleeping", {31'd0, bus.sleeping}, 32'd0);
        chk("reset.ovf", {31'd0, bus.stk_ovf}, 32'd0);
        chk("reset.unf", {31'd0, bus.stk_unf}, 32'd0);
        rst_n = 1'b1;

        // Sequential fetch with wrap, wake ignored while awake
        step(); chk_fetch("seq0", 11'h000, 12'h7FF);
        bus.wake = 1'b1;
        step(); chk_fetch("seq1", 11'h001, 12'h000);
        bus.wake = 1'b0;
        chk("seq1.sleeping", {31'd0, bus.sleeping}, 32'd0);
        step(); chk_fetch("seq2", 11'h002, 12'h001);

        // GOTO 0x155 at 0x010 with pa=01
        pcl_jump(8'h0F);
        step(); chk_fetch("pre_goto", 11'h010, 12'h00F);
        step(); chk_fetch("at_goto", 11'h011, 12'h155);
        bus.pa = 2'b01; bus.goto = 1'b1;
        step(); chk_fetch("goto", 11'h355, 12'h000);
        bus.goto = 1'b0; bus.pa = 2'b00;
        step(); chk_fetch("goto_tgt", 11'h356, 12'h355);

        // CALL 0x40 at 0x020, then RETLW back to 0x021
        pcl_jump(8'h1F);
        step(); chk_fetch("pre_call", 11'h020, 12'h01F);
        step(); chk_fetch("at_call", 11'h021, 12'h940);
        bus.call = 1'b1;
        step(); chk_fetch("call", 11'h040, 12'h000);
        bus.call = 1'b0;
        step(); chk_fetch("call_tgt", 11'h041, 12'h040);
        bus.retlw = 1'b1;
        step(); chk_fetch("retlw", 11'h021, 12'h000);
        bus.retlw = 1'b0;
        step(); chk_fetch("ret_tgt", 11'h022, 12'h021);
        chk("ret.unf", {31'd0, bus.stk_unf}, 32'd0);

        // Three nested CALLs, three RETLWs
        pcl_jump(8'h60);
        step(); chk_fetch("n0", 11'h061, 12'h970);
        bus.call = 1'b1;
        step(); chk_fetch("call1", 11'h070, 12'h000);
        bus.call = 1'b0;
        step(); chk_fetch("n1", 11'h071, 12'h980);
        bus.call = 1'b1;
        step(); chk_fetch("call2", 11'h080, 12'h000);
        chk("call2.ovf", {31'd0, bus.stk_ovf}, 32'd0);
        bus.call = 1'b0;
        step(); chk_fetch("n2", 11'h081, 12'h990);
        bus.call = 1'b1;
        step(); chk_fetch("call3", 11'h090, 12'h000);
        bus.call = 1'b0;
        chk("call3.ovf", {31'd0, bus.stk_ovf}, {31'd0, STK_CHK});
        bus.retlw = 1'b1;
        step(); chk_fetch("ret1", 11'h081, 12'h000);
        step(); chk_fetch("ret2", 11'h071, 12'h000);
        chk("ret2.unf", {31'd0, bus.stk_unf}, 32'd0);
        step(); chk_fetch("ret3", 11'h071, 12'h000);
        bus.retlw = 1'b0;
        chk("ret3.unf", {31'd0, bus.stk_unf}, {31'd0, STK_CHK});
        chk("ret3.ovf_sticky", {31'd0, bus.stk_ovf}, {31'd0, STK_CHK});

        // Skip at 0x030 squashes 0x031
        pcl_jump(8'h2F);
        step(); chk_fetch("pre_skip", 11'h030, 12'h02F);
        step(); chk_fetch("at_skip", 11'h031, 12'h030);
        bus.skip = 1'b1;
        step(); chk_fetch("skip", 11'h032, 12'h000);
        bus.skip = 1'b0;
        step(); chk_fetch("post_skip", 11'h033, 12'h032);

        // goto beats pcl_wr and skip
        bus.goto = 1'b1; bus.pcl_wr = 1'b1; bus.skip = 1'b1;
        bus.pcl_data = 8'hAA; bus.pa = 2'b11;
        step(); chk_fetch("prio", 11'h632, 12'h000);
        bus.goto = 1'b0; bus.pcl_wr = 1'b0; bus.skip = 1'b0;

        // SLEEP at 0x050, goto ignored while asleep, wake resumes at 0x051
        pcl_jump(8'h4F);
        step(); chk_fetch("pre_sleep", 11'h050, 12'h04F);
        step(); chk_fetch("at_sleep", 11'h051, 12'h050);
        bus.sleep = 1'b1;
        step(); chk_fetch("sleep", 11'h051, 12'h000);
        chk("sleep.sleeping", {31'd0, bus.sleeping}, 32'd1);
        bus.sleep = 1'b0; bus.goto = 1'b1; bus.pa = 2'b01;
        for (int i = 0; i < 10; i++) begin
            step(); chk_fetch("asleep", 11'h051, 12'h000);
        end
        bus.goto = 1'b0; bus.wake = 1'b1;
        step(); chk_fetch("wake", 11'h051, 12'h000);
        chk("wake.sleeping", {31'd0, bus.sleeping}, 32'd0);
        bus.wake = 1'b0;
        step(); chk_fetch("post_wake", 11'h052, 12'h051);

        // Reset while sleeping
        bus.sleep = 1'b1;
        step(); chk("sleep2.sleeping", {31'd0, bus.sleeping}, 32'd1);
        bus.sleep = 1'b0;
        rst_n = 1'b0;
        step(); chk_fetch("rst_sleep", 11'h7FF, 12'h000);
        chk("rst_sleep.sleeping", {31'd0, bus.sleeping}, 32'd0);
        chk("rst_sleep.ovf", {31'd0, bus.stk_ovf}, 32'd0);
        chk("rst_sleep.unf", {31'd0, bus.stk_unf}, 32'd0);
        rst_n = 1'b1;
        step(); chk_fetch("rst_resume", 11'h000, 12'h7FF);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
